// File: rtl/core_pkg.sv
// Shared types and defaults for the core bus arbiter.
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_t;

    typedef enum logic {
        ARB_INST = 1'b0,
        ARB_DATA = 1'b1
    } arb_src_t;

    localparam int ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/core_bus_arb_timer.sv
// Response timeout counter: counts enabled cycles, saturates, and flags expiry
// when the count reaches TIMEOUT_CYCLES-1 while enabled. TIMEOUT_CYCLES = 0 disables expiry.
module core_bus_arb_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] CNT_TC  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES > 0) && en_i && (cnt_q == CNT_TC);

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one memory bus between the fetch (inst) and mem-stage (data) channels,
// one transaction outstanding. Define CORE_BUS_ARB_ROUND_ROBIN_EN for alternating priority.
//   state    | meaning
//   ARB_IDLE | no transaction; arbitrate on any request
//   ARB_REQ  | bus request driven for owner, waiting for mem_grnt_i
//   ARB_RSP  | waiting for mem_valid_i or timeout
module core_bus_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    parameter int CNT_W          = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_req_i,
    output logic              inst_grnt_o,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_valid_o,
    input  logic              data_req_i,
    output logic              data_grnt_o,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic              data_wen_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_valid_o,
    output logic              mem_req_o,
    input  logic              mem_grnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wen_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_valid_i,
    output logic              err_o,
    output logic              err_src_o
);

    arb_state_t state_q, state_d;
    arb_src_t   owner_q, owner_d;
    arb_src_t   last_owner_q, last_owner_d;
    arb_src_t   err_src_q, err_src_d;
    arb_src_t   arb_win;

    logic any_req;
    logic rsp_fire;
    logic abort;
    logic tmr_expired;

    assign any_req = inst_req_i | data_req_i;

`ifdef CORE_BUS_ARB_ROUND_ROBIN_EN
    // A back-to-back arbitration in RSP must see the owner that is just completing.
    arb_src_t last_sel;
    always_comb begin
        last_sel = (state_q == ARB_RSP) ? owner_q : last_owner_q;
        if (inst_req_i && data_req_i) begin
            arb_win = (last_sel == ARB_DATA) ? ARB_INST : ARB_DATA;
        end else begin
            arb_win = data_req_i ? ARB_DATA : ARB_INST;
        end
    end
`else
    logic last_owner_unused;
    assign arb_win           = data_req_i ? ARB_DATA : ARB_INST;
    assign last_owner_unused = last_owner_q;
`endif

    core_bus_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     ((state_q == ARB_REQ) && mem_grnt_i),
        .en_i      ((state_q == ARB_RSP) && !mem_valid_i),
        .expired_o (tmr_expired)
    );

    // Reset mid-transaction must complete nothing, so both completions are gated by rst_i.
    assign rsp_fire = (state_q == ARB_RSP) && mem_valid_i && !rst_i;
    assign abort    = tmr_expired && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_INST;
            last_owner_q <= ARB_INST;
            err_src_q    <= ARB_INST;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            err_src_q    <= err_src_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        err_src_d    = err_src_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    owner_d = arb_win;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (mem_grnt_i) begin
                    state_d = ARB_RSP;
                end
            end
            ARB_RSP: begin
                if (rsp_fire) begin
                    last_owner_d = owner_q;
                    if (any_req) begin
                        owner_d = arb_win;
                        state_d = ARB_REQ;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (abort) begin
                    err_src_d = owner_q;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_wen_o    = 1'b0;
        inst_grnt_o  = 1'b0;
        data_grnt_o  = 1'b0;
        inst_valid_o = 1'b0;
        data_valid_o = 1'b0;
        inst_rdata_o = '0;
        data_rdata_o = '0;
        err_o        = abort;
        err_src_o    = abort ? owner_q : err_src_q;
        if (state_q == ARB_REQ) begin
            mem_req_o = 1'b1;
            if (owner_q == ARB_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
                mem_wen_o   = data_wen_i;
                data_grnt_o = mem_grnt_i;
            end else begin
                mem_addr_o  = inst_addr_i;
                inst_grnt_o = mem_grnt_i;
            end
        end
        // An abort returns a valid with zero data to the owner.
        if (rsp_fire || abort) begin
            if (owner_q == ARB_DATA) begin
                data_valid_o = 1'b1;
                data_rdata_o = rsp_fire ? mem_rdata_i : '0;
            end else begin
                inst_valid_o = 1'b1;
                inst_rdata_o = rsp_fire ? mem_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter (TIMEOUT_CYCLES = 4); honours CORE_BUS_ARB_ROUND_ROBIN_EN.
module tb_core_bus_arbiter;

`ifdef CORE_BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_wen, mem_grnt, mem_valid;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic        inst_grnt_o, inst_valid_o, data_grnt_o, data_valid_o;
    logic        mem_req_o, mem_wen_o, err_o, err_src_o;
    logic [31:0] inst_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;

    int vectors = 0;
    int miscompares = 0;

    logic w;
    logic e;
    logic exp_last;

    always #5 clk = ~clk;

    core_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_req_i(inst_req), .inst_grnt_o(inst_grnt_o), .inst_addr_i(inst_addr),
        .inst_rdata_o(inst_rdata_o), .inst_valid_o(inst_valid_o),
        .data_req_i(data_req), .data_grnt_o(data_grnt_o), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_wen_i(data_wen),
        .data_rdata_o(data_rdata_o), .data_valid_o(data_valid_o),
        .mem_req_o(mem_req_o), .mem_grnt_i(mem_grnt), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wen_o(mem_wen_o), .mem_rdata_i(mem_rdata),
        .mem_valid_i(mem_valid), .err_o(err_o), .err_src_o(err_src_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1; outputs are compared at posedge+2.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #0;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected winner (1 = data) from the arbitration rules.
    function automatic logic pick(input logic ireq, input logic dreq, input logic last);
        if (ireq && dreq && RR) return !last;
        return dreq;
    endfunction

    initial begin
        rst = 1'b1; inst_req = 0; data_req = 0; data_wen = 0; mem_grnt = 0; mem_valid = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
        exp_last = 1'b0;
        repeat (2) tick;
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_grnts", {inst_grnt_o, data_grnt_o}, 0);
        chk("rst_valids", {inst_valid_o, data_valid_o}, 0);
        chk("rst_err", {err_o, err_src_o}, 0);
        rst = 1'b0;

        // Single inst read
        tick;
        inst_req = 1; inst_addr = 32'h100; #1;
        chk("t1_arb_cycle_no_req", mem_req_o, 0);
        tick; #1;
        chk("t1_mem_req", mem_req_o, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_no_grnt_yet", inst_grnt_o, 0);
        tick; #1;
        chk("t1_still_req", mem_req_o, 1);
        mem_grnt = 1; #1;
        chk("t1_inst_grnt", inst_grnt_o, 1);
        chk("t1_data_grnt", data_grnt_o, 0);
        chk("t1_wen", mem_wen_o, 0);
        tick;
        mem_grnt = 0; inst_req = 0; #1;
        chk("t1_rsp_no_req", mem_req_o, 0);
        tick; tick;
        mem_valid = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_inst_valid", inst_valid_o, 1);
        chk("t1_inst_rdata", inst_rdata_o, 32'hDEADBEEF);
        chk("t1_data_silent", {data_valid_o, data_grnt_o}, 0);
        chk("t1_data_rdata", data_rdata_o, 0);
        chk("t1_no_err", err_o, 0);
        tick;
        mem_valid = 0; #1;
        chk("t1_idle", {mem_req_o, inst_valid_o}, 0);
        exp_last = 1'b0;

        // Data write with immediate grant
        data_req = 1; data_addr = 32'h2000; data_wdata = 32'h12345678; data_wen = 1;
        tick;
        mem_grnt = 1; #1;
        chk("t2_wen", mem_wen_o, 1);
        chk("t2_addr", mem_addr_o, 32'h2000);
        chk("t2_wdata", mem_wdata_o, 32'h12345678);
        chk("t2_data_grnt", data_grnt_o, 1);
        chk("t2_inst_grnt", inst_grnt_o, 0);
        tick;
        mem_grnt = 0; data_req = 0; mem_valid = 1; mem_rdata = 32'h0; #1;
        chk("t2_data_valid", data_valid_o, 1);
        chk("t2_inst_valid", inst_valid_o, 0);
        tick;
        mem_valid = 0; data_wen = 0;
        exp_last = 1'b1;

        // Simultaneous requests, loser issued back-to-back
        inst_req = 1; inst_addr = 32'h300; data_req = 1; data_addr = 32'h400;
        w = pick(1'b1, 1'b1, exp_last);
        tick; #1;
        chk("t3_first_addr", mem_addr_o, w ? 32'h400 : 32'h300);
        mem_grnt = 1; #1;
        chk("t3_win_grnt", w ? data_grnt_o : inst_grnt_o, 1);
        chk("t3_lose_grnt", w ? inst_grnt_o : data_grnt_o, 0);
        tick;
        mem_grnt = 0;
        if (w) data_req = 0; else inst_req = 0;
        tick;
        mem_valid = 1; mem_rdata = 32'hA5A5A5A5; #1;
        chk("t3_win_valid", w ? data_valid_o : inst_valid_o, 1);
        chk("t3_lose_valid", w ? inst_valid_o : data_valid_o, 0);
        chk("t3_win_rdata", w ? data_rdata_o : inst_rdata_o, 32'hA5A5A5A5);
        chk("t3_lose_rdata", w ? inst_rdata_o : data_rdata_o, 0);
        tick;
        mem_valid = 0; #1;
        chk("t3_b2b_req", mem_req_o, 1);
        chk("t3_b2b_addr", mem_addr_o, w ? 32'h300 : 32'h400);
        mem_grnt = 1; #1;
        chk("t3_lose_grnt2", w ? inst_grnt_o : data_grnt_o, 1);
        tick;
        mem_grnt = 0; inst_req = 0; data_req = 0;
        mem_valid = 1; mem_rdata = 32'h0BADF00D; #1;
        chk("t3_lose_valid2", w ? inst_valid_o : data_valid_o, 1);
        chk("t3_lose_rdata2", w ? inst_rdata_o : data_rdata_o, 32'h0BADF00D);
        tick;
        mem_valid = 0;
        exp_last = !w;

        // Sustained contention for 6 transactions
        inst_req = 1; inst_addr = 32'h800; data_req = 1; data_addr = 32'h900;
        tick;
        for (int i = 0; i < 6; i++) begin
            e = pick(1'b1, 1'b1, exp_last);
            #1;
            chk("t4_owner_addr", mem_addr_o, e ? 32'h900 : 32'h800);
            mem_grnt = 1; #1;
            chk("t4_owner_grnt", e ? data_grnt_o : inst_grnt_o, 1);
            chk("t4_other_grnt", e ? inst_grnt_o : data_grnt_o, 0);
            tick;
            mem_grnt = 0;
            if (i == 5) begin
                inst_req = 0; data_req = 0;
            end
            mem_valid = 1; mem_rdata = 32'(i + 1); #1;
            chk("t4_owner_valid", e ? data_valid_o : inst_valid_o, 1);
            chk("t4_owner_rdata", e ? data_rdata_o : inst_rdata_o, 32'(i + 1));
            exp_last = e;
            tick;
            mem_valid = 0;
        end
        #1;
        chk("t4_idle_after", mem_req_o, 0);

        // Timeout on a data read
        data_req = 1; data_addr = 32'h500; data_wen = 0;
        tick;
        mem_grnt = 1; #1;
        chk("t5_grnt", data_grnt_o, 1);
        tick;
        mem_grnt = 0; data_req = 0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("t5_no_err_early", {err_o, data_valid_o}, 0);
            tick;
        end
        #1;
        chk("t5_abort_valid", data_valid_o, 1);
        chk("t5_abort_rdata", data_rdata_o, 0);
        chk("t5_err", err_o, 1);
        chk("t5_err_src", err_src_o, 1);
        chk("t5_inst_quiet", inst_valid_o, 0);
        tick; #1;
        chk("t5_err_pulse", err_o, 0);
        chk("t5_err_src_hold", err_src_o, 1);
        tick;
        mem_valid = 1; mem_rdata = 32'hFFFF; #1;
        chk("t5_late_ignored", {data_valid_o, inst_valid_o}, 0);
        tick;
        mem_valid = 0; #1;
        chk("t5_no_state_change", mem_req_o, 0);

        // Reset while in RSP
        inst_req = 1; inst_addr = 32'h600;
        tick;
        mem_grnt = 1;
        tick;
        mem_grnt = 0; inst_req = 0; rst = 1; #1;
        chk("t6_rst_cycle_quiet", {inst_valid_o, err_o}, 0);
        tick;
        rst = 0; #1;
        chk("t6_post_rst_outs", {mem_req_o, inst_grnt_o, data_grnt_o, inst_valid_o, data_valid_o, err_o, err_src_o}, 0);
        chk("t6_post_rst_addr", mem_addr_o, 0);
        mem_valid = 1; mem_rdata = 32'h1234; #1;
        chk("t6_late_ignored", inst_valid_o, 0);
        tick;
        mem_valid = 0; inst_req = 1; inst_addr = 32'h700;
        tick; #1;
        chk("t6_new_req", mem_req_o, 1);
        chk("t6_new_addr", mem_addr_o, 32'h700);
        mem_grnt = 1; #1;
        chk("t6_new_grnt", inst_grnt_o, 1);
        tick;
        mem_grnt = 0; inst_req = 0; mem_valid = 1; mem_rdata = 32'hCAFEF00D; #1;
        chk("t6_new_valid", inst_valid_o, 1);
        chk("t6_new_rdata", inst_rdata_o, 32'hCAFEF00D);
        tick;
        mem_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
